// File: rtl/merge_fetch_arbiter.sv
// merge_fetch_arbiter
//   Feeds the four coordinate inputs of a quaternary merge tree. Holds one
//   fiber descriptor per lane, issues tagged 64-bit reads through one shared
//   memory port (round-robin, credit limited to DEPTH per lane), and buffers
//   returning coordinates in a per-lane prefetch FIFO whose head is shown to
//   the merger.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   start                     load descriptors (ignored while busy)
//   base_addr, fiber_len      packed per-lane descriptors
//   mem_req_*                 read request channel (valid/ready, addr, lane tag)
//   mem_rsp_*                 read response channel (valid, lane tag, data)
//   coord_0..coord_3          lane heads, all-ones sentinel once exhausted
//   heads_valid               every lane has a real head or is exhausted
//   fetch_next                per-lane pop requests from the merger
//   busy, done                running flag, one-cycle completion pulse
module merge_fetch_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [4*ADDR_W-1:0] base_addr,
  input  logic [4*LEN_W-1:0]  fiber_len,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [1:0]          mem_req_lane,
  input  logic                mem_rsp_valid,
  input  logic [1:0]          mem_rsp_lane,
  input  logic [63:0]         mem_rsp_data,
  output logic [63:0]         coord_0,
  output logic [63:0]         coord_1,
  output logic [63:0]         coord_2,
  output logic [63:0]         coord_3,
  output logic                heads_valid,
  input  logic [3:0]          fetch_next,
  output logic                busy,
  output logic                done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam logic [63:0] SENTINEL = '1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;

  logic [ADDR_W-1:0] addr      [4];
  logic [LEN_W-1:0]  issue_cnt [4];
  logic [CW-1:0]     outst     [4];
  logic [CW-1:0]     occ       [4];
  logic [PW-1:0]     rd_ptr    [4];
  logic [PW-1:0]     wr_ptr    [4];
  logic [63:0]       buffer    [4][DEPTH];
  logic [63:0]       coord     [4];

  logic [1:0]        rr_ptr;
  logic              hold_valid;
  logic [1:0]        hold_lane;
  logic [ADDR_W-1:0] hold_addr;

  logic [3:0]        eligible, exhausted, nonempty, push, pop, grant_hit;
  logic              grant_any, accept, all_exh;
  logic [1:0]        grant_lane, req_lane;
  logic [ADDR_W-1:0] req_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    eligible  = '0;
    exhausted = '0;
    nonempty  = '0;
    push      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      nonempty[i]  = (occ[i] != '0);
      exhausted[i] = (issue_cnt[i] == '0) && (outst[i] == '0) && !nonempty[i];
      eligible[i]  = (state == RUN) && (issue_cnt[i] != '0) &&
                     (({1'b0, occ[i]} + {1'b0, outst[i]}) < SW'(DEPTH));
      // Pushes are only taken for lanes with a read in flight, so responses
      // from a run aborted by reset cannot corrupt a later run's FIFO.
      push[i]      = (state == RUN) && mem_rsp_valid && (mem_rsp_lane == 2'(i)) &&
                     (outst[i] != '0);
    end
  end

  always_comb begin
    logic [1:0] cand;
    grant_any  = 1'b0;
    grant_lane = rr_ptr;
    cand       = rr_ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!grant_any && eligible[cand]) begin
        grant_any  = 1'b1;
        grant_lane = cand;
      end
    end
  end

  // A request that has been shown but not accepted is frozen in the hold
  // registers, so later pops cannot change the presented lane or address.
  always_comb begin
    req_lane      = hold_valid ? hold_lane : grant_lane;
    req_addr      = hold_valid ? hold_addr : addr[grant_lane];
    mem_req_valid = (state == RUN) && (hold_valid || grant_any);
    mem_req_lane  = mem_req_valid ? req_lane : '0;
    mem_req_addr  = mem_req_valid ? req_addr : '0;
    accept        = mem_req_valid && mem_req_ready;
    for (int unsigned i = 0; i < 4; i++) begin
      grant_hit[i] = accept && (req_lane == 2'(i));
    end
  end

  always_comb begin
    all_exh     = &exhausted;
    busy        = (state == RUN);
    heads_valid = (state == RUN) && (&(nonempty | exhausted));
    done        = (state == RUN) && all_exh;
    pop         = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      pop[i]   = heads_valid && fetch_next[i] && nonempty[i];
      coord[i] = nonempty[i] ? buffer[i][rd_ptr[i]] : SENTINEL;
    end
    state_next = state;
    case (state)
      IDLE:    if (start)   state_next = RUN;
      RUN:     if (all_exh) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign coord_0 = coord[0];
  assign coord_1 = coord[1];
  assign coord_2 = coord[2];
  assign coord_3 = coord[3];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      hold_valid <= 1'b0;
      hold_lane  <= '0;
      hold_addr  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        addr[i]      <= '0;
        issue_cnt[i] <= '0;
        outst[i]     <= '0;
        occ[i]       <= '0;
        rd_ptr[i]    <= '0;
        wr_ptr[i]    <= '0;
      end
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        hold_valid <= 1'b0;
        if (start) begin
          for (int unsigned i = 0; i < 4; i++) begin
            addr[i]      <= base_addr[i*ADDR_W +: ADDR_W];
            issue_cnt[i] <= fiber_len[i*LEN_W +: LEN_W];
            outst[i]     <= '0;
            occ[i]       <= '0;
            rd_ptr[i]    <= '0;
            wr_ptr[i]    <= '0;
          end
        end
      end else begin
        hold_valid <= mem_req_valid && !mem_req_ready;
        if (mem_req_valid && !mem_req_ready) begin
          hold_lane <= req_lane;
          hold_addr <= req_addr;
        end
        if (accept) rr_ptr <= req_lane + 2'd1;
        for (int unsigned i = 0; i < 4; i++) begin
          if (grant_hit[i]) begin
            addr[i]      <= addr[i] + ADDR_W'(8);
            issue_cnt[i] <= issue_cnt[i] - LEN_W'(1);
          end
          if (grant_hit[i] && !push[i])      outst[i] <= outst[i] + 1'b1;
          else if (!grant_hit[i] && push[i]) outst[i] <= outst[i] - 1'b1;
          if (push[i] && !pop[i])            occ[i] <= occ[i] + 1'b1;
          else if (pop[i] && !push[i])       occ[i] <= occ[i] - 1'b1;
          if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
          if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (push[i]) buffer[i][wr_ptr[i]] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_merge_fetch_arbiter.sv
module tb_merge_fetch_arbiter;

  localparam int DEPTH = 2;
  localparam logic [63:0] SENT = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] base_addr = '0;
  logic [63:0]  fiber_len = '0;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [31:0]  mem_req_addr;
  logic [1:0]   mem_req_lane;
  logic         mem_rsp_valid = 1'b0;
  logic [1:0]   mem_rsp_lane = '0;
  logic [63:0]  mem_rsp_data = '0;
  logic [63:0]  coord_0, coord_1, coord_2, coord_3;
  logic         heads_valid;
  logic [3:0]   fetch_next = '0;
  logic         busy, done;

  merge_fetch_arbiter #(.DEPTH(DEPTH), .ADDR_W(32), .LEN_W(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .base_addr(base_addr), .fiber_len(fiber_len),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_lane(mem_req_lane),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_lane(mem_rsp_lane),
    .mem_rsp_data(mem_rsp_data),
    .coord_0(coord_0), .coord_1(coord_1), .coord_2(coord_2), .coord_3(coord_3),
    .heads_valid(heads_valid), .fetch_next(fetch_next),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [63:0] coord [4];
  assign coord[0] = coord_0;
  assign coord[1] = coord_1;
  assign coord[2] = coord_2;
  assign coord[3] = coord_3;

  int vecs = 0;
  int errs = 0;

  // Memory content: a fixed function of the byte address, never all-ones.
  function automatic logic [63:0] mem_data(input logic [31:0] a);
    return {a ^ 32'h5A5A_1234, ~a};
  endfunction

  // Reference model: per lane, how many reads were accepted, answered and
  // popped. Occupancy + in-flight = accepted - popped; exhausted = popped == len.
  bit          mon_en = 0;
  bit          m_busy = 0;
  int          m_len [4];
  int          m_acc [4];
  int          m_rcv [4];
  int          m_pop [4];
  logic [31:0] m_base [4];
  int          cyc = 0;
  int          dut_done = 0;
  int          grants [$];
  bit          prev_stall = 0;
  logic [1:0]  prev_lane;
  logic [31:0] prev_addr;

  typedef struct {
    logic [1:0]  lane;
    logic [63:0] data;
    int          due;
  } rsp_t;
  rsp_t pend [$];

  int lat_max = 1;
  int ready_pct = 100;
  int rsp_pct = 100;
  int rsp_budget = 1000000;
  int pop_mode = 0;   // 0 none, 1 one-hot round robin, 2 random, 3 driven by a task
  int pop_rr = 0;

  always @(negedge clock) begin : monitor
    bit          exh [4];
    bit          hv_exp, all_exh, done_exp;
    int          l;
    logic [31:0] exp_a;
    if (mon_en) begin
      all_exh = 1;
      hv_exp  = m_busy;
      for (int i = 0; i < 4; i++) begin
        exh[i] = !m_busy || (m_pop[i] == m_len[i]);
        if (!exh[i]) all_exh = 0;
        if (!(exh[i] || m_rcv[i] > m_pop[i])) hv_exp = 0;
      end
      done_exp = m_busy && all_exh;

      vecs++;
      if (busy !== m_busy) begin
        errs++; $display("FAIL busy @%0d: got %b want %b", cyc, busy, m_busy);
      end
      vecs++;
      if (heads_valid !== hv_exp) begin
        errs++; $display("FAIL heads_valid @%0d: got %b want %b", cyc, heads_valid, hv_exp);
      end
      vecs++;
      if (done !== done_exp) begin
        errs++; $display("FAIL done @%0d: got %b want %b", cyc, done, done_exp);
      end
      for (int i = 0; i < 4; i++) begin
        if (exh[i]) begin
          vecs++;
          if (coord[i] !== SENT) begin
            errs++; $display("FAIL sentinel lane%0d @%0d: got %h want %h", i, cyc, coord[i], SENT);
          end
        end else if (m_rcv[i] > m_pop[i]) begin
          vecs++;
          if (coord[i] !== mem_data(m_base[i] + 32'(8 * m_pop[i]))) begin
            errs++; $display("FAIL head lane%0d @%0d: got %h want %h", i, cyc, coord[i],
                             mem_data(m_base[i] + 32'(8 * m_pop[i])));
          end
        end
      end
      if (!m_busy) begin
        vecs++;
        if (mem_req_valid !== 1'b0) begin
          errs++; $display("FAIL idle_req @%0d: got %b want 0", cyc, mem_req_valid);
        end
      end else if (mem_req_valid === 1'b1) begin
        l = int'(mem_req_lane);
        exp_a = m_base[l] + 32'(8 * m_acc[l]);
        vecs++;
        if (!(m_acc[l] < m_len[l] && m_acc[l] - m_pop[l] < DEPTH)) begin
          errs++; $display("FAIL req_credit lane%0d @%0d: got acc=%0d pop=%0d want acc<%0d and acc-pop<%0d",
                           l, cyc, m_acc[l], m_pop[l], m_len[l], DEPTH);
        end
        vecs++;
        if (mem_req_addr !== exp_a) begin
          errs++; $display("FAIL req_addr lane%0d @%0d: got %h want %h", l, cyc, mem_req_addr, exp_a);
        end
      end
      if (prev_stall) begin
        vecs++;
        if (mem_req_valid !== 1'b1 || mem_req_lane !== prev_lane || mem_req_addr !== prev_addr) begin
          errs++; $display("FAIL req_hold @%0d: got v=%b lane=%0d addr=%h want v=1 lane=%0d addr=%h",
                           cyc, mem_req_valid, mem_req_lane, mem_req_addr, prev_lane, prev_addr);
        end
      end
      if (done === 1'b1) dut_done++;

      // Effects of the coming rising edge.
      if (reset) begin
        m_busy = 0;
        prev_stall = 0;
        for (int i = 0; i < 4; i++) begin
          m_acc[i] = 0; m_rcv[i] = 0; m_pop[i] = 0; m_len[i] = 0;
        end
      end else if (m_busy) begin
        prev_stall = (mem_req_valid === 1'b1) && !mem_req_ready;
        prev_lane  = mem_req_lane;
        prev_addr  = mem_req_addr;
        if (mem_req_valid === 1'b1 && mem_req_ready) begin
          l = int'(mem_req_lane);
          grants.push_back(l);
          pend.push_back('{lane: mem_req_lane, data: mem_data(mem_req_addr),
                           due: cyc + int'($urandom_range(lat_max, 1))});
          m_acc[l]++;
        end
        for (int i = 0; i < 4; i++)
          if (hv_exp && fetch_next[i] && m_rcv[i] > m_pop[i]) m_pop[i]++;
        if (mem_rsp_valid) m_rcv[mem_rsp_lane]++;
        if (done_exp) m_busy = 0;
      end else if (start) begin
        m_busy = 1;
        prev_stall = 0;
        for (int i = 0; i < 4; i++) begin
          m_len[i]  = int'(fiber_len[i*16 +: 16]);
          m_base[i] = base_addr[i*32 +: 32];
          m_acc[i] = 0; m_rcv[i] = 0; m_pop[i] = 0;
        end
      end
    end
    cyc++;
  end

  // Memory: in-order responses after a per-request latency.
  always @(posedge clock) begin
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc && rsp_budget > 0 &&
        $urandom_range(99, 0) < 32'(rsp_pct)) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_lane  = pend[0].lane;
      mem_rsp_data  = pend[0].data;
      void'(pend.pop_front());
      rsp_budget--;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_lane  = 2'($urandom);
      mem_rsp_data  = {$urandom, $urandom};
    end
    mem_req_ready = ($urandom_range(99, 0) < 32'(ready_pct));
    case (pop_mode)
      0: fetch_next = '0;
      1: begin
        if (heads_valid) begin
          fetch_next = 4'b0001 << pop_rr;
          pop_rr = (pop_rr + 1) % 4;
        end else fetch_next = '0;
      end
      2: fetch_next = 4'($urandom);
      default: ;
    endcase
  end

  task automatic do_start(input logic [127:0] b, input logic [63:0] l);
    @(posedge clock); #2;
    base_addr = b; fiber_len = l; start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int t;
    for (t = 0; t < bound && m_busy; t++) begin
      @(posedge clock); #2;
    end
    vecs++;
    if (m_busy) begin
      errs++; $display("FAIL %s_timeout: got busy after %0d cycles want idle", name, bound);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vecs++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== '0 || mem_req_lane !== '0 ||
        heads_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        coord_0 !== SENT || coord_1 !== SENT || coord_2 !== SENT || coord_3 !== SENT) begin
      errs++;
      $display("FAIL %s: got v=%b a=%h l=%0d hv=%b busy=%b done=%b c0=%h c3=%h want reset values",
               name, mem_req_valid, mem_req_addr, mem_req_lane, heads_valid, busy, done, coord_0, coord_3);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    mon_en = 1;
    @(negedge clock);
    check_reset_outputs("reset_values");
  endtask

  task automatic test_basic;
    int bad, d0;
    ready_pct = 100; lat_max = 1; rsp_pct = 100; pop_mode = 1; pop_rr = 0;
    grants.delete(); d0 = dut_done;
    do_start({32'h300, 32'h200, 32'h100, 32'h000}, {16'd3, 16'd3, 16'd3, 16'd3});
    wait_idle(300, "basic");
    bad = 0;
    foreach (grants[k]) if (grants[k] != k % 4) bad++;
    vecs++;
    if (grants.size() != 12 || bad != 0) begin
      errs++; $display("FAIL basic_grant_order: got %0d grants, %0d out of order want 12 in order", grants.size(), bad);
    end
    vecs++;
    if (dut_done - d0 != 1) begin
      errs++; $display("FAIL basic_done_count: got %0d want 1", dut_done - d0);
    end
    pop_mode = 0;
  endtask

  task automatic test_zero_unequal;
    int d0;
    pop_mode = 1; grants.delete(); d0 = dut_done;
    do_start({32'h3000, 32'h2000, 32'h1000, 32'h0800}, {16'd2, 16'd0, 16'd1, 16'd0});
    @(negedge clock);
    vecs++;
    if (coord_0 !== SENT || coord_2 !== SENT) begin
      errs++; $display("FAIL zero_len_sentinel: got c0=%h c2=%h want %h", coord_0, coord_2, SENT);
    end
    wait_idle(200, "zero_unequal");
    vecs++;
    if (grants.size() != 3) begin
      errs++; $display("FAIL zero_unequal_requests: got %0d want 3", grants.size());
    end
    vecs++;
    if (dut_done - d0 != 1) begin
      errs++; $display("FAIL zero_unequal_done: got %0d want 1", dut_done - d0);
    end
    pop_mode = 0;
  endtask

  task automatic test_backpressure;
    logic [31:0] a_exp;
    pop_mode = 0; ready_pct = 100; grants.delete();
    do_start({32'h0, 32'h0, 32'h0, 32'hFFFF_FFF0}, {16'd0, 16'd0, 16'd0, 16'd5});
    repeat (10) @(posedge clock);
    @(negedge clock);
    vecs++;
    if (grants.size() != 2 || mem_req_valid !== 1'b0) begin
      errs++; $display("FAIL credit_limit: got %0d grants valid=%b want 2 grants valid=0", grants.size(), mem_req_valid);
    end
    @(posedge clock); #2;
    ready_pct = 0; pop_mode = 3; fetch_next = 4'b0001;
    @(posedge clock); #2;
    fetch_next = '0;
    a_exp = 32'hFFFF_FFF0 + 32'd16;
    for (int t = 0; t < 4; t++) begin
      @(negedge clock);
      vecs++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== a_exp || mem_req_lane !== 2'd0 || mem_req_ready !== 1'b0) begin
        errs++; $display("FAIL stall_hold cyc%0d: got v=%b a=%h l=%0d r=%b want v=1 a=%h l=0 r=0",
                         t, mem_req_valid, mem_req_addr, mem_req_lane, mem_req_ready, a_exp);
      end
    end
    ready_pct = 100; pop_mode = 1;
    wait_idle(200, "backpressure");
    vecs++;
    if (grants.size() != 5) begin
      errs++; $display("FAIL backpressure_requests: got %0d want 5", grants.size());
    end
    pop_mode = 0;
  endtask

  task automatic test_collision;
    int t;
    pop_mode = 3; fetch_next = '0; ready_pct = 100; rsp_budget = 0;
    do_start({32'h0, 32'h0, 32'h0, 32'h1000}, {16'd0, 16'd0, 16'd0, 16'd2});
    for (t = 0; t < 30 && pend.size() < 2; t++) begin
      @(posedge clock); #2;
    end
    vecs++;
    if (pend.size() != 2) begin
      errs++; $display("FAIL collision_requests: got %0d want 2", pend.size());
    end
    rsp_budget = 1;
    for (t = 0; t < 30; t++) begin
      @(negedge clock);
      if (coord_0 === mem_data(32'h1000)) break;
    end
    vecs++;
    if (coord_0 !== mem_data(32'h1000)) begin
      errs++; $display("FAIL collision_first_head: got %h want %h", coord_0, mem_data(32'h1000));
    end
    rsp_budget = 1;
    @(posedge clock); #2;
    fetch_next = 4'b0001;
    vecs++;
    if (mem_rsp_valid !== 1'b1 || mem_rsp_lane !== 2'd0) begin
      errs++; $display("FAIL collision_same_cycle: got rsp_v=%b lane=%0d want 1 lane 0", mem_rsp_valid, mem_rsp_lane);
    end
    @(posedge clock); #2;
    @(negedge clock);
    vecs++;
    if (coord_0 !== mem_data(32'h1008) || heads_valid !== 1'b1 || done !== 1'b0) begin
      errs++; $display("FAIL collision_new_head: got %h hv=%b done=%b want %h hv=1 done=0",
                       coord_0, heads_valid, done, mem_data(32'h1008));
    end
    @(posedge clock); #2;
    fetch_next = '0;
    @(negedge clock);
    vecs++;
    if (done !== 1'b1) begin
      errs++; $display("FAIL collision_occupancy: got done=%b want 1 after single pop", done);
    end
    rsp_budget = 1000000; pop_mode = 1;
    wait_idle(50, "collision");
    pop_mode = 0;
  endtask

  task automatic test_midrun_reset;
    int t, d0;
    logic [63:0] lens;
    pop_mode = 0; ready_pct = 100; rsp_budget = 0;
    do_start({$urandom, $urandom, $urandom, $urandom}, {16'd4, 16'd4, 16'd4, 16'd4});
    for (t = 0; t < 30 && pend.size() < 3; t++) begin
      @(posedge clock); #2;
    end
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("midrun_reset_values");
    rsp_budget = 1000000;
    for (t = 0; t < 30; t++) begin
      @(negedge clock);
      vecs++;
      if (busy !== 1'b0 || heads_valid !== 1'b0 || coord_0 !== SENT || coord_1 !== SENT ||
          coord_2 !== SENT || coord_3 !== SENT) begin
        errs++; $display("FAIL late_rsp_dropped: got busy=%b hv=%b c0=%h want idle sentinels", busy, heads_valid, coord_0);
      end
      if (pend.size() == 0 && mem_rsp_valid === 1'b0) break;
    end
    d0 = dut_done;
    for (int i = 0; i < 4; i++) lens[i*16 +: 16] = 16'($urandom_range(5, 0));
    pop_mode = 1;
    do_start({$urandom, $urandom, $urandom, $urandom}, lens);
    wait_idle(500, "after_reset");
    vecs++;
    if (dut_done - d0 != 1) begin
      errs++; $display("FAIL after_reset_done: got %0d want 1", dut_done - d0);
    end
    pop_mode = 0;
  endtask

  task automatic test_all_zero;
    grants.delete();
    @(posedge clock); #2;
    base_addr = {$urandom, $urandom, $urandom, $urandom}; fiber_len = '0; start = 1'b1;
    @(posedge clock); #2;
    @(negedge clock);
    vecs++;
    if (busy !== 1'b1 || done !== 1'b1 || mem_req_valid !== 1'b0) begin
      errs++; $display("FAIL all_zero_done: got busy=%b done=%b v=%b want 1 1 0", busy, done, mem_req_valid);
    end
    @(posedge clock); #2;
    start = 1'b0;
    @(negedge clock);
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || grants.size() != 0) begin
      errs++; $display("FAIL start_while_busy: got busy=%b done=%b grants=%0d want 0 0 0", busy, done, grants.size());
    end
  endtask

  task automatic test_random;
    logic [63:0] lens;
    int d0;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) lens[i*16 +: 16] = 16'($urandom_range(6, 0));
      lat_max = int'($urandom_range(3, 1));
      ready_pct = int'($urandom_range(100, 30));
      rsp_pct = int'($urandom_range(100, 40));
      pop_mode = 2;
      d0 = dut_done;
      do_start({$urandom, $urandom, $urandom, $urandom}, lens);
      wait_idle(3000, "random");
      vecs++;
      if (dut_done - d0 != 1) begin
        errs++; $display("FAIL random_done run%0d: got %0d want 1", r, dut_done - d0);
      end
    end
    pop_mode = 0; ready_pct = 100; rsp_pct = 100; lat_max = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_unequal();
    test_backpressure();
    test_collision();
    test_midrun_reset();
    test_all_zero();
    test_random();
    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
